wb_mem_arbiter: RTL and testbench
=================================

# wb_mem_arbiter

Two-master, one-slave Wishbone (pipelined, stall/ack) arbiter sharing the single `memdev` memory between the instruction-fetch bus (ibus, from `fetch`) and the data bus (dbus, from `mem`). It sits in `top` between the pipeline stages and `memdev`. A registered grant FSM gives one master the whole Wishbone cycle at a time, holding the grant until that master drops `cyc`. Stall and ack are routed only to the owner.

## Interface
- `AW`, 18: word-address width forwarded to the slave (20-bit byte space).
- `DW`, 32: data width; `sel` width is `DW/8`.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `i_ibus_cyc`, `i_ibus_stb`, `i_ibus_we`  in  1 each  ibus master controls
- `i_ibus_addr`  in  AW  ibus word address
- `i_ibus_data`  in  DW  ibus write data
- `i_ibus_sel`  in  DW/8  ibus byte selects
- `o_ibus_ack`, `o_ibus_stall`  out  1 each  ibus ack / stall
- `o_ibus_data`  out  DW  ibus read data
- `i_dbus_*`, `o_dbus_*`  same set and widths as ibus, for the data master
- `o_mem_cyc`, `o_mem_stb`, `o_mem_we`  out  1 each  to slave
- `o_mem_addr`  out  AW; `o_mem_data`  out  DW; `o_mem_sel`  out  DW/8
- `i_mem_ack`, `i_mem_stall`  in  1 each  from slave
- `i_mem_data`  in  DW  slave read data
- `o_grant`  out  2  one-hot owner: bit0 ibus, bit1 dbus, 00 idle

## Operation
- FSM states: IDLE, GNT_I, GNT_D. The state is registered. `last` is a registered flag recording the most recently granted master.
- IDLE:
  - only `i_dbus_cyc` high -> GNT_D.
  - only `i_ibus_cyc` high -> GNT_I.
  - both high -> winner per Configuration.
  - neither high -> stay in IDLE.
- GNT_x while `i_x_cyc` is high: stay in GNT_x. Grant is never preempted.
- GNT_x when `i_x_cyc` goes low:
  - other master's `cyc` high -> go directly to that grant (one-cycle handover).
  - otherwise -> IDLE.
- Slave outputs are combinational muxes of the owner's signals.
  - `o_mem_cyc` = owner `cyc`; `o_mem_stb` = owner `stb`.
  - In IDLE, `o_mem_cyc` and `o_mem_stb` are 0. `addr`/`data`/`sel`/`we` are don't-care but driven from ibus.
- Return path to the owner: `o_x_stall` = `i_mem_stall`, `o_x_ack` = `i_mem_ack`.
- Return path to the non-owner (and to both in IDLE): `stall` = 1, `ack` = 0.
- `i_mem_data` goes to both `o_ibus_data` and `o_dbus_data` unconditionally.
- An `i_mem_ack` arriving in IDLE is discarded. An ack arriving after a handover goes to the new owner; masters must not drop `cyc` with acks outstanding.
- `o_grant` decodes the current state.

## Timing
- Reset (synchronous): state = IDLE, `last` = ibus.
  - Hence after reset: `o_mem_cyc`=0, `o_mem_stb`=0, `o_ibus_stall`=`o_dbus_stall`=1, both acks 0, `o_grant`=00.
- Reset mid-transaction: at the reset edge the grant is lost and the slave sees `cyc` fall. The in-flight ack is dropped.
- Arbitration latency: a `cyc` rise in IDLE at cycle N gives a grant at N+1. The master's `stb` reaches the slave at N+1 and is accepted at N+1 if `i_mem_stall`=0.
- The requesting master holds `stb` while its `stall` is 1. This is standard Wishbone and needs no extra buffering.
- Release: owner `cyc` low at cycle M:
  - pending other master -> new grant at M+1.
  - no pending master -> IDLE at M+1.
- A master that drops and re-raises `cyc` in consecutive cycles loses at most one cycle.
- All paths other than the state register are combinational; no added latency on ack or data.

## Configuration
- `WB_ARB_ROUND_ROBIN_EN`
  - Defined: simultaneous requests in IDLE are granted to the master not equal to `last`. `last` updates on every entry to a GNT state.
  - Undefined: fixed priority; dbus always wins in IDLE. `last` is still maintained but unused.
- Handover from GNT_x is identical in both modes.

## Test plan
- Reset with both `cyc` high -> during reset `o_grant`=00, `o_mem_cyc`=0, both stalls 1. One cycle after reset deasserts, `o_grant`=10 in both modes.
- ibus-only read of addr 0x10 (slave returns 0x00000013, ack 1 cycle after accept) -> `o_grant`=01 the cycle after `cyc` rises. `o_ibus_ack` pulses once with `o_ibus_data`=0x00000013. `o_dbus_ack` stays 0.
- dbus write 0xDEADBEEF, sel 4'b1111, while ibus holds `cyc`/`stb` -> ibus stalled throughout. Slave sees `we`=1, data 0xDEADBEEF. On dbus `cyc` drop the grant hands directly to ibus (`o_grant` 10 -> 01 in one cycle).
- Both masters request continuously, each dropping `cyc` after one ack:
  - round-robin build: grants alternate D,I,D,I.
  - fixed-priority build: ibus is granted only while dbus `cyc` is low.
- Slave asserts `i_mem_stall` for 3 cycles during a dbus burst of 2 stb -> exactly 2 accepted transfers, `o_dbus_stall` mirrors `i_mem_stall`, 2 acks.
- Reset asserted mid-dbus transaction with ack due next cycle -> the next cycle shows IDLE, and the stray `i_mem_ack` does not appear on either master.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter
//   Two-master / one-slave pipelined Wishbone arbiter. The instruction-fetch
//   bus (ibus) and data bus (dbus) share one memory slave. A registered grant
//   FSM hands the whole Wishbone cycle to one master and holds it until that
//   master drops cyc. Everything downstream of the state register is
//   combinational, so ack and read data see no added latency.
//
//   Build option: WB_ARB_ROUND_ROBIN_EN
//     defined   - simultaneous requests in IDLE go to the master that was not
//                 granted most recently
//     undefined - fixed priority, dbus wins simultaneous requests in IDLE
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   i_ibus_* / o_ibus_*         instruction master: cyc/stb/we/addr/data/sel
//                               in, ack/stall/data out
//   i_dbus_* / o_dbus_*         data master, same set as ibus
//   o_mem_*                     muxed request to the slave
//   i_mem_ack/stall/data        slave response
//   o_grant                     one-hot owner: bit0 ibus, bit1 dbus, 00 idle
module wb_mem_arbiter #(
    parameter int AW = 18,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            i_ibus_cyc,
    input  logic            i_ibus_stb,
    input  logic            i_ibus_we,
    input  logic [AW-1:0]   i_ibus_addr,
    input  logic [DW-1:0]   i_ibus_data,
    input  logic [DW/8-1:0] i_ibus_sel,
    output logic            o_ibus_ack,
    output logic            o_ibus_stall,
    output logic [DW-1:0]   o_ibus_data,

    input  logic            i_dbus_cyc,
    input  logic            i_dbus_stb,
    input  logic            i_dbus_we,
    input  logic [AW-1:0]   i_dbus_addr,
    input  logic [DW-1:0]   i_dbus_data,
    input  logic [DW/8-1:0] i_dbus_sel,
    output logic            o_dbus_ack,
    output logic            o_dbus_stall,
    output logic [DW-1:0]   o_dbus_data,

    output logic            o_mem_cyc,
    output logic            o_mem_stb,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_data,
    output logic [DW/8-1:0] o_mem_sel,
    input  logic            i_mem_ack,
    input  logic            i_mem_stall,
    input  logic [DW-1:0]   i_mem_data,

    output logic [1:0]      o_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;     // most recent grant: 0 ibus, 1 dbus
    state_t both_win;
    logic   own_i, own_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Winner when both masters raise cyc while the bus is idle.
`ifdef WB_ARB_ROUND_ROBIN_EN
    assign both_win = last_q ? GNT_I : GNT_D;
`else
    assign both_win = GNT_D;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_ibus_cyc && i_dbus_cyc) state_d = both_win;
                else if (i_dbus_cyc)          state_d = GNT_D;
                else if (i_ibus_cyc)          state_d = GNT_I;
            end
            // The owner keeps the bus until it drops cyc; a waiting master
            // then takes over on the very next cycle without passing IDLE.
            GNT_I: if (!i_ibus_cyc) state_d = i_dbus_cyc ? GNT_D : IDLE;
            GNT_D: if (!i_dbus_cyc) state_d = i_ibus_cyc ? GNT_I : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == GNT_I)      last_d = 1'b0;
        else if (state_d == GNT_D) last_d = 1'b1;
    end

    assign own_i = (state_q == GNT_I);
    assign own_d = (state_q == GNT_D);

    // Request path: cyc/stb gated by ownership so IDLE shows nothing to the
    // slave; the remaining fields default to ibus when dbus does not own.
    assign o_mem_cyc  = (own_i & i_ibus_cyc) | (own_d & i_dbus_cyc);
    assign o_mem_stb  = (own_i & i_ibus_stb) | (own_d & i_dbus_stb);
    assign o_mem_we   = own_d ? i_dbus_we   : i_ibus_we;
    assign o_mem_addr = own_d ? i_dbus_addr : i_ibus_addr;
    assign o_mem_data = own_d ? i_dbus_data : i_ibus_data;
    assign o_mem_sel  = own_d ? i_dbus_sel  : i_ibus_sel;

    // Return path: only the owner sees the slave; everyone else is stalled
    // and never acked, which also swallows acks arriving while idle.
    assign o_ibus_stall = own_i ? i_mem_stall : 1'b1;
    assign o_ibus_ack   = own_i & i_mem_ack;
    assign o_dbus_stall = own_d ? i_mem_stall : 1'b1;
    assign o_dbus_ack   = own_d & i_mem_ack;
    assign o_ibus_data  = i_mem_data;
    assign o_dbus_data  = i_mem_data;

    assign o_grant = {own_d, own_i};

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Testbench for wb_mem_arbiter: two random Wishbone masters and a random-stall
// memory slave around the DUT. A rule-level arbitration model predicts the
// owner every cycle; per-master queues hold expected responses pushed when a
// request is accepted and popped by the monitor on each ack.
module tb_wb_mem_arbiter;
    localparam int AW = 18;
    localparam int DW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    sel;
    } req_t;

    typedef struct packed {
        logic          rd;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          m_cyc [2];
    logic          m_stb [2];
    logic          m_we  [2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_data[2];
    logic [3:0]    m_sel [2];

    logic o_ibus_ack, o_ibus_stall, o_dbus_ack, o_dbus_stall;
    logic [DW-1:0] o_ibus_data, o_dbus_data;
    logic o_mem_cyc, o_mem_stb, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_data;
    logic [3:0]    o_mem_sel;
    logic i_mem_ack = 1'b0, i_mem_stall = 1'b0;
    logic [DW-1:0] i_mem_data = '0;
    logic [1:0] o_grant;

    wb_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .i_ibus_cyc(m_cyc[0]), .i_ibus_stb(m_stb[0]), .i_ibus_we(m_we[0]),
        .i_ibus_addr(m_addr[0]), .i_ibus_data(m_data[0]), .i_ibus_sel(m_sel[0]),
        .o_ibus_ack(o_ibus_ack), .o_ibus_stall(o_ibus_stall), .o_ibus_data(o_ibus_data),
        .i_dbus_cyc(m_cyc[1]), .i_dbus_stb(m_stb[1]), .i_dbus_we(m_we[1]),
        .i_dbus_addr(m_addr[1]), .i_dbus_data(m_data[1]), .i_dbus_sel(m_sel[1]),
        .o_dbus_ack(o_dbus_ack), .o_dbus_stall(o_dbus_stall), .o_dbus_data(o_dbus_data),
        .o_mem_cyc(o_mem_cyc), .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_sel(o_mem_sel),
        .i_mem_ack(i_mem_ack), .i_mem_stall(i_mem_stall), .i_mem_data(i_mem_data),
        .o_grant(o_grant)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Reference memory seen by the masters and the slave's own storage.
    logic [31:0] ref_mem  [256];
    logic [31:0] slv_mem  [256];
    rsp_t        exq [2][$];
    req_t        slq [$];

    // Arbitration model: 0 idle, 1 ibus, 2 dbus; last 0 ibus, 1 dbus.
    int   m_owner = 0;
    int   m_last  = 0;
    logic mon_en  = 1'b0;
    logic acc_f [2];
    logic mem_acc_f = 1'b0;
    req_t mem_req_f;

    logic ack_m, stall_m;
    logic [DW-1:0] dat_m;
    rsp_t r;
    req_t q;
    int   nxt;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("grant", {62'd0, o_grant},
                {62'd0, (m_owner == 2) ? 1'b1 : 1'b0, (m_owner == 1) ? 1'b1 : 1'b0});
            chk("mem_cyc", o_mem_cyc, (m_owner == 1) ? m_cyc[0] : (m_owner == 2) ? m_cyc[1] : 1'b0);
            chk("mem_stb", o_mem_stb, (m_owner == 1) ? m_stb[0] : (m_owner == 2) ? m_stb[1] : 1'b0);
            chk("ibus_stall", o_ibus_stall, (m_owner == 1) ? i_mem_stall : 1'b1);
            chk("dbus_stall", o_dbus_stall, (m_owner == 2) ? i_mem_stall : 1'b1);
            chk("ibus_ack", o_ibus_ack, (m_owner == 1) ? i_mem_ack : 1'b0);
            chk("dbus_ack", o_dbus_ack, (m_owner == 2) ? i_mem_ack : 1'b0);
            chk("ibus_data", o_ibus_data, i_mem_data);
            chk("dbus_data", o_dbus_data, i_mem_data);

            for (int m = 0; m < 2; m++) begin
                ack_m   = m ? o_dbus_ack   : o_ibus_ack;
                stall_m = m ? o_dbus_stall : o_ibus_stall;
                dat_m   = m ? o_dbus_data  : o_ibus_data;
                if (ack_m) begin
                    if (exq[m].size() == 0) chk(m ? "dbus_stray_ack" : "ibus_stray_ack", 1, 0);
                    else begin
                        r = exq[m].pop_front();
                        if (r.rd) chk(m ? "dbus_rdata" : "ibus_rdata", dat_m, r.data);
                    end
                end
                acc_f[m] = m_cyc[m] && m_stb[m] && !stall_m;
                if (acc_f[m]) begin
                    q = '{we: m_we[m], addr: m_addr[m], data: m_data[m], sel: m_sel[m]};
                    slq.push_back(q);
                    if (q.we) begin
                        ref_mem[q.addr[7:0]] = merge(ref_mem[q.addr[7:0]], q.data, q.sel);
                        exq[m].push_back('{rd: 1'b0, data: '0});
                    end else begin
                        exq[m].push_back('{rd: 1'b1, data: ref_mem[q.addr[7:0]]});
                    end
                end
            end

            mem_acc_f = o_mem_cyc && o_mem_stb && !i_mem_stall;
            if (mem_acc_f) begin
                mem_req_f = '{we: o_mem_we, addr: o_mem_addr, data: o_mem_data, sel: o_mem_sel};
                if (slq.size() == 0) chk("mem_spurious_accept", 1, 0);
                else begin
                    q = slq.pop_front();
                    chk("mem_req", {9'd0, mem_req_f}, {9'd0, q});
                end
            end

            // Next owner from the arbitration rules.
            if (reset) begin
                nxt = 0;
                m_last = 0;
            end else begin
                if (m_owner == 1 && m_cyc[0])      nxt = 1;
                else if (m_owner == 2 && m_cyc[1]) nxt = 2;
                else if (m_owner == 1)             nxt = m_cyc[1] ? 2 : 0;
                else if (m_owner == 2)             nxt = m_cyc[0] ? 1 : 0;
                else if (m_cyc[0] && m_cyc[1]) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
                    nxt = (m_last == 1) ? 1 : 2;
`else
                    nxt = 2;
`endif
                end
                else if (m_cyc[1]) nxt = 2;
                else if (m_cyc[0]) nxt = 1;
                else               nxt = 0;
                if (nxt != 0) m_last = nxt - 1;
            end
            m_owner = nxt;

            if (reset) begin
                exq[0].delete();
                exq[1].delete();
                slq.delete();
            end
        end
    end

    logic act [2];
    int   rem [2];
    int   rst_left = 0;
    logic drain = 1'b0;

    task automatic gen_req(input int m);
        m_we[m]   = 1'($urandom_range(0, 1));
        m_addr[m] = AW'($urandom_range(0, 31));
        m_data[m] = $urandom;
        m_sel[m]  = m_we[m] ? 4'($urandom_range(1, 15)) : 4'hf;
    endtask

    task automatic master_step(input int m);
        if (reset) begin
            act[m] = 1'b0; m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
        end else if (!act[m]) begin
            if (!drain && $urandom_range(0, 2) == 0) begin
                act[m] = 1'b1; rem[m] = $urandom_range(1, 3);
                m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
                gen_req(m);
            end
        end else begin
            if (acc_f[m]) begin
                rem[m]--;
                if (rem[m] > 0) gen_req(m);
                else m_stb[m] = 1'b0;
            end
            if (!m_stb[m] && exq[m].size() == 0) begin
                m_cyc[m] = 1'b0; act[m] = 1'b0;
            end
        end
    endtask

    task automatic slave_step();
        if (mem_acc_f) begin
            i_mem_ack = 1'b1;
            if (mem_req_f.we) begin
                slv_mem[mem_req_f.addr[7:0]] = merge(slv_mem[mem_req_f.addr[7:0]],
                                                     mem_req_f.data, mem_req_f.sel);
                i_mem_data = $urandom;
            end else begin
                i_mem_data = slv_mem[mem_req_f.addr[7:0]];
            end
        end else begin
            i_mem_ack  = 1'b0;
            i_mem_data = $urandom;
        end
        i_mem_stall = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'(i + 3);
            slv_mem[i] = 32'(i + 3);
        end
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 1'b1; m_stb[m] = 1'b0; m_we[m] = 1'b0;
            m_addr[m] = '0; m_data[m] = '0; m_sel[m] = 4'hf;
            act[m] = 1'b1; rem[m] = 0; acc_f[m] = 1'b0;
        end
        mem_req_f = '0;

        // Both masters request through reset; dbus must win on release.
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("grant_after_reset", {62'd0, o_grant}, 64'd2);

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            slave_step();
            master_step(0);
            master_step(1);
            if (rst_left > 0) begin
                reset = 1'b1; rst_left--;
            end else if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1; rst_left = 1;
            end else begin
                reset = 1'b0;
            end
        end

        drain = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            slave_step();
            master_step(0);
            master_step(1);
            reset = 1'b0;
        end
        @(negedge clk);
        chk("ibus_outstanding", exq[0].size(), 0);
        chk("dbus_outstanding", exq[1].size(), 0);
        chk("slave_outstanding", slq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
